// File: rtl/stream_token_bucket.sv
// stream_token_bucket: token-bucket rate limiter for a valid/ready stream.
// Payload passes straight through with no storage. Only the handshake is gated
// by the token count, so a beat is never buffered inside this block.
// Optional build macro STREAM_TOKEN_BUCKET_STATS_EN adds a saturating
// throttle-stall counter on stall_cnt_o. Without the macro, stall_cnt_o is tied to 0.
module stream_token_bucket #(
  parameter type         payload_t       = logic,
  parameter int unsigned MaxTokens       = 16,
  parameter int unsigned InitTokens      = 16,
  parameter int unsigned RefillPeriod    = 4,
  parameter int unsigned TokensPerRefill = 1,
  localparam int unsigned TokW           = $clog2(MaxTokens + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            bypass_i,
  input  payload_t        payload_i,
  input  logic            valid_i,
  output logic            ready_o,
  output payload_t        payload_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [TokW-1:0] tokens_o,
  output logic [31:0]     stall_cnt_o
);

  // The adder is wide enough for a refill amount larger than the bucket.
  // The result is then saturated back to MaxTokens.
  localparam int unsigned TprW   = $clog2(TokensPerRefill + 1);
  localparam int unsigned SumW   = ((TokW > TprW) ? TokW : TprW) + 1;
  localparam int unsigned PrescW = (RefillPeriod > 1) ? $clog2(RefillPeriod) : 1;

  // Reject parameter sets that cannot describe a valid bucket.
  if (MaxTokens < 1) begin : g_err_max
    $error("stream_token_bucket: MaxTokens must be >= 1");
  end
  if (InitTokens > MaxTokens) begin : g_err_init
    $error("stream_token_bucket: InitTokens must be <= MaxTokens");
  end
  if (RefillPeriod < 1) begin : g_err_period
    $error("stream_token_bucket: RefillPeriod must be >= 1");
  end
  if (TokensPerRefill < 1) begin : g_err_tpr
    $error("stream_token_bucket: TokensPerRefill must be >= 1");
  end

  logic [TokW-1:0]   tokens_q, tokens_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [SumW-1:0]   sum;
  logic              avail;
  logic              consume;
  logic              refill;

  // Handshake gating: a beat may pass only while a token exists or bypass is set.
  always_comb begin
    avail     = bypass_i | (tokens_q != '0);
    valid_o   = valid_i & avail;
    ready_o   = ready_i & avail;
    payload_o = payload_i;
    consume   = valid_i & ready_i & avail & ~bypass_i;
  end

  // Free-running refill prescaler. It keeps counting during bypass.
  always_comb begin
    refill  = (presc_q == PrescW'(RefillPeriod - 1));
    presc_d = refill ? '0 : presc_q + PrescW'(1);
  end

  // Next token count: spend, then refill, then saturate. Bypass pins the bucket full.
  always_comb begin
    sum      = SumW'(tokens_q) - SumW'(consume)
             + (refill ? SumW'(TokensPerRefill) : SumW'(0));
    tokens_d = (sum > SumW'(MaxTokens)) ? TokW'(MaxTokens) : TokW'(sum);
    if (bypass_i) begin
      tokens_d = TokW'(MaxTokens);
    end
  end

  // Bucket and prescaler state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tokens_q <= TokW'(InitTokens);
      presc_q  <= '0;
    end else begin
      tokens_q <= tokens_d;
      presc_q  <= presc_d;
    end
  end

  assign tokens_o = tokens_q;

`ifdef STREAM_TOKEN_BUCKET_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where upstream offers a beat but the bucket is empty. The count saturates.
  always_comb begin
    stall_d = stall_q;
    if (valid_i && !avail && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_token_bucket.sv
// Bench for stream_token_bucket. Two instances share the same stimulus.
// Instance 0 starts with a full bucket and instance 1 starts empty.
// Both are checked every cycle against an arithmetic token-bucket model.
module tb_stream_token_bucket;

  localparam int MAXT = 16;
  localparam int RP   = 4;
  localparam int TPR  = 1;
  localparam int TOKW = 5;
  localparam int INIT0 = 16;
  localparam int INIT1 = 0;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       bypass_i;
  logic [7:0] payload_i;
  logic       valid_i;
  logic       ready_i;

  logic            valid_w   [2];
  logic            ready_w   [2];
  logic [7:0]      payload_w [2];
  logic [TOKW-1:0] tokens_w  [2];
  logic [31:0]     stall_w   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  stream_token_bucket #(
    .payload_t(logic [7:0]), .MaxTokens(MAXT), .InitTokens(INIT0),
    .RefillPeriod(RP), .TokensPerRefill(TPR)
  ) dut_full (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i),
    .payload_i(payload_i), .valid_i(valid_i), .ready_o(ready_w[0]),
    .payload_o(payload_w[0]), .valid_o(valid_w[0]), .ready_i(ready_i),
    .tokens_o(tokens_w[0]), .stall_cnt_o(stall_w[0])
  );

  stream_token_bucket #(
    .payload_t(logic [7:0]), .MaxTokens(MAXT), .InitTokens(INIT1),
    .RefillPeriod(RP), .TokensPerRefill(TPR)
  ) dut_empty (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i),
    .payload_i(payload_i), .valid_i(valid_i), .ready_o(ready_w[1]),
    .payload_o(payload_w[1]), .valid_o(valid_w[1]), .ready_i(ready_i),
    .tokens_o(tokens_w[1]), .stall_cnt_o(stall_w[1])
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: token count as a plain integer. A refill occurs on every
  // RP-th cycle since reset.
  int     m_tok   [2];
  longint m_stall [2];
  int     m_cyc;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_cyc = 0;
        m_tok[0] = INIT0;
        m_tok[1] = INIT1;
        m_stall[0] = 0;
        m_stall[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit av, cons, rf;
          int t;
          av   = bypass_i || (m_tok[i] > 0);
          cons = valid_i && ready_i && av && !bypass_i;
          rf   = ((m_cyc % RP) == RP - 1);
          chk($sformatf("valid_o[%0d]", i), longint'(valid_w[i]), longint'(valid_i && av));
          chk($sformatf("ready_o[%0d]", i), longint'(ready_w[i]), longint'(ready_i && av));
          chk($sformatf("payload_o[%0d]", i), longint'(payload_w[i]), longint'(payload_i));
          chk($sformatf("tokens_o[%0d]", i), longint'(tokens_w[i]), longint'(m_tok[i]));
`ifdef STREAM_TOKEN_BUCKET_STATS_EN
          chk($sformatf("stall_cnt_o[%0d]", i), longint'(stall_w[i]), m_stall[i]);
`else
          chk($sformatf("stall_cnt_o[%0d]", i), longint'(stall_w[i]), 0);
`endif
          if (valid_i && !av && m_stall[i] < 64'h0000_0000_FFFF_FFFF) m_stall[i]++;
          t = m_tok[i] - (cons ? 1 : 0) + (rf ? TPR : 0);
          m_tok[i] = bypass_i ? MAXT : ((t > MAXT) ? MAXT : t);
        end
        m_cyc++;
      end
    end
  end

  // Stimulus and hand-computed pins.
  initial begin
    int  beats;
    int  beats1;
    bit  found;
    rst_ni = 1'b0; bypass_i = 1'b0; payload_i = 8'h00; valid_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Continuous traffic from reset: a burst on the full bucket, a stall on the empty one.
    beats = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk_i);
      if (valid_w[0] && ready_w[0]) beats++;
      if (k == 0) begin
        chk("reset tokens full", longint'(tokens_w[0]), 16);
        chk("reset tokens empty", longint'(tokens_w[1]), 0);
        chk("reset stall", longint'(stall_w[1]), 0);
      end
      if (k <= 3) chk("empty valid_o low", longint'(valid_w[1]), 0);
      if (k == 1) chk("burst tokens step", longint'(tokens_w[0]), 15);
      if (k == 4) begin
        chk("empty first token", longint'(tokens_w[1]), 1);
        chk("empty first beat", longint'(valid_w[1]), 1);
`ifdef STREAM_TOKEN_BUCKET_STATS_EN
        chk("stall count 4", longint'(stall_w[1]), 4);
`else
        chk("stall count off", longint'(stall_w[1]), 0);
`endif
      end
      if (k == 5) chk("empty spent", longint'(tokens_w[1]), 0);
      if (k == 21) chk("burst exhausted", longint'(valid_w[0]), 0);
      if (k == 24) chk("burst paced beat", longint'(valid_w[0]), 1);
      payload_i = 8'(k);
      @(posedge clk_i); #1;
    end
    chk("burst beat count", longint'(beats), 27);

    // Backpressure: no token is spent and refills saturate at MaxTokens.
    ready_i = 1'b0;
    repeat (70) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    chk("backpressure saturate", longint'(tokens_w[0]), 16);
    chk("backpressure valid held", longint'(valid_w[0]), 1);
    chk("backpressure ready low", longint'(ready_w[0]), 0);
    @(posedge clk_i); #1;

    // Drain the full instance to an empty bucket, then switch on bypass.
    ready_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk_i); #1;
      if (tokens_w[0] == '0) begin found = 1'b1; break; end
    end
    chk("drain reached empty", longint'(found), 1);
    bypass_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bypass refills full", longint'(tokens_w[0]), 16);
    beats = 0; beats1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (valid_w[0] && ready_w[0]) beats++;
      if (valid_w[1] && ready_w[1]) beats1++;
      payload_i = payload_i;
      @(posedge clk_i); #1;
    end
    chk("bypass beats 0", longint'(beats), 40);
    chk("bypass beats 1", longint'(beats1), 40);
    chk("bypass tokens held", longint'(tokens_w[0]), 16);
    bypass_i = 1'b0;

    // Random traffic, including occasional bypass, checked by the model.
    for (int k = 0; k < 3000; k++) begin
      bypass_i  = ($urandom_range(0, 31) == 0);
      valid_i   = ($urandom_range(0, 3) != 0);
      ready_i   = ($urandom_range(0, 2) != 0);
      payload_i = 8'($urandom);
      @(posedge clk_i); #1;
    end
    bypass_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;

    // Asynchronous reset in mid-cycle returns state at once.
    repeat (3) begin @(posedge clk_i); #1; end
    #2 rst_ni = 1'b0;
    #1;
    chk("async reset tokens full", longint'(tokens_w[0]), 16);
    chk("async reset tokens empty", longint'(tokens_w[1]), 0);
    chk("async reset stall", longint'(stall_w[1]), 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (12) begin @(posedge clk_i); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
